// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared constants, state codes and helpers for the Fibonacci display
//
// Contents:
//   SEG_0..SEG_9, SEG_BLANK, SEG_E : active-low 7-segment patterns, bit order gfedcba
//   IDLE, LOAD, CONVERT, UPDATE    : display FSM state codes
//   clog2()                        : ceiling log2, minimum result 1 (safe as a vector width)
//   seg_decode()                   : BCD nibble to 7-segment pattern
package fib_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] CONVERT = 2'd2;
  localparam logic [1:0] UPDATE  = 2'd3;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fib_seq_display_bin2bcd.sv
// rtl/fib_seq_display_bin2bcd.sv - sequential double-dabble binary to BCD converter
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   start  in   load bin and clear the accumulator (overrides a conversion in flight)
//   bin    in   WIDTH-bit binary value sampled on start
//   done   out  high during the last of the WIDTH iterations; bcd is final from the next cycle
//   bcd    out  DIGITS packed BCD nibbles, digit 0 in [3:0]
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  import fib_pkg::*;

  localparam int             CW   = clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]    shreg;
  logic [CW-1:0]       cnt;
  logic                active;
  logic [4*DIGITS-1:0] adj;

  // Add-3 correction on every nibble that would reach 10 or more after the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = active && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      shreg  <= bin;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      bcd    <= {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
      shreg  <= shreg << 1;
      cnt    <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/fib_seq_display.sv
// rtl/fib_seq_display.sv - Fibonacci sequence generator with BCD 7-segment display
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   run      in   level, auto-advance on each prescaled tick
//   step     in   pulse, advance one term while run=0
//   restart  in   pulse, return to term 0 (beats run/step in the same cycle)
//   hex      out  DIGITS*7 active-low segments, digit i at [7i+6:7i], gfedcba
//   value    out  currently displayed term
//   ovf      out  overflow flag (sticky, or a 1-cycle pulse when wrapping)
//   busy     out  BCD conversion in progress
module fib_seq_display #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int TICK_DIV    = 25000000,
  parameter int WRAP_ON_OVF = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                restart,
  output logic [DIGITS*7-1:0] hex,
  output logic [WIDTH-1:0]    value,
  output logic                ovf,
  output logic                busy
);
  import fib_pkg::*;

  localparam int            TW        = clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic          WRAP      = (WRAP_ON_OVF != 0);

  localparam logic [DIGITS*7-1:0] HEX_ZERO = {{(DIGITS-1){SEG_BLANK}}, SEG_0};
  localparam logic [DIGITS*7-1:0] HEX_ERR  = {DIGITS{SEG_E}};

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [WIDTH-1:0]    cur;
  logic [WIDTH-1:0]    nxt;
  logic                nxt_ovf;
  logic                pending;
  logic [1:0]          state;
  logic [WIDTH:0]      sum;
  logic                blocked;
  logic                adv;
  logic                go;
  logic                conv_done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS*7-1:0] hex_next;
  logic                lead;

  assign tick    = (tick_cnt == TICK_LAST);
  // A frozen overflow swallows every advance until restart or reset.
  assign blocked = ovf && !WRAP;
  assign adv     = (run ? tick : step) && !blocked;
  assign go      = (adv || pending) && !blocked;
  assign sum     = {1'b0, cur} + {1'b0, nxt};

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (state == LOAD),
    .bin   (cur),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Leading-zero blanking scans from the most significant digit; digit 0 always shows.
  always_comb begin
    hex_next = '0;
    lead     = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i != 0 && lead && bcd[4*i +: 4] == 4'd0) begin
        hex_next[7*i +: 7] = SEG_BLANK;
      end else begin
        lead               = 1'b0;
        hex_next[7*i +: 7] = seg_decode(bcd[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      cur      <= '0;
      nxt      <= WIDTH'(1);
      nxt_ovf  <= 1'b0;
      ovf      <= 1'b0;
      pending  <= 1'b0;
      state    <= LOAD;
      busy     <= 1'b0;
      hex      <= HEX_ZERO;
      value    <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      // In wrap mode ovf is a single-cycle pulse; the set below wins when it fires.
      if (WRAP) ovf <= 1'b0;
      if (restart) begin
        tick_cnt <= '0;
        cur      <= '0;
        nxt      <= WIDTH'(1);
        nxt_ovf  <= 1'b0;
        ovf      <= 1'b0;
        pending  <= 1'b0;
        state    <= LOAD;
        busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              pending <= 1'b0;
              if (nxt_ovf) begin
                ovf <= 1'b1;
                if (WRAP) begin
                  cur     <= '0;
                  nxt     <= WIDTH'(1);
                  nxt_ovf <= 1'b0;
                  state   <= LOAD;
                  busy    <= 1'b1;
                end else begin
                  hex <= HEX_ERR;
                end
              end else begin
                cur     <= nxt;
                nxt     <= sum[WIDTH-1:0];
                nxt_ovf <= sum[WIDTH];
                state   <= LOAD;
                busy    <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (adv) pending <= 1'b1;
            state <= CONVERT;
            busy  <= 1'b1;
          end
          CONVERT: begin
            if (adv) pending <= 1'b1;
            if (conv_done) begin
              state <= UPDATE;
              busy  <= 1'b0;
            end
          end
          default: begin
            if (adv) pending <= 1'b1;
            hex   <= hex_next;
            value <= cur;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fib_seq_display.sv
// tb/tb_fib_seq_display.sv - scoreboard bench for fib_seq_display in three configurations
module tb_fib_seq_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 0: W16/D5 freeze, instance 1: W8/D3 freeze, instance 2: W8/D3 wrap.
  logic rst[3];
  logic run[3];
  logic step[3];
  logic rsr[3];

  logic [34:0] hex_a;
  logic [20:0] hex_b, hex_c;
  logic [15:0] val_a;
  logic [7:0]  val_b, val_c;
  logic        ovf_a, ovf_b, ovf_c, busy_a, busy_b, busy_c;

  logic [34:0] hx[3];
  logic [15:0] vl[3];
  logic        bz[3];
  logic        of[3];

  fib_seq_display #(.WIDTH(16), .DIGITS(5), .TICK_DIV(4), .WRAP_ON_OVF(0)) u_a (
    .clk(clk), .reset(rst[0]), .run(run[0]), .step(step[0]), .restart(rsr[0]),
    .hex(hex_a), .value(val_a), .ovf(ovf_a), .busy(busy_a));
  fib_seq_display #(.WIDTH(8), .DIGITS(3), .TICK_DIV(4), .WRAP_ON_OVF(0)) u_b (
    .clk(clk), .reset(rst[1]), .run(run[1]), .step(step[1]), .restart(rsr[1]),
    .hex(hex_b), .value(val_b), .ovf(ovf_b), .busy(busy_b));
  fib_seq_display #(.WIDTH(8), .DIGITS(3), .TICK_DIV(4), .WRAP_ON_OVF(1)) u_c (
    .clk(clk), .reset(rst[2]), .run(run[2]), .step(step[2]), .restart(rsr[2]),
    .hex(hex_c), .value(val_c), .ovf(ovf_c), .busy(busy_c));

  always_comb begin
    hx[0] = hex_a;             hx[1] = {14'd0, hex_b};   hx[2] = {14'd0, hex_c};
    vl[0] = val_a;             vl[1] = {8'd0, val_b};    vl[2] = {8'd0, val_c};
    bz[0] = busy_a;            bz[1] = busy_b;           bz[2] = busy_c;
    of[0] = ovf_a;             of[1] = ovf_b;            of[2] = ovf_c;
  end

  logic [6:0] segtab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct packed {
    logic [34:0] h;
    logic [15:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // Reference display: decimal digits by division, blank above the highest non-zero digit.
  function automatic logic [34:0] exp_hex(int v, int nd);
    logic [34:0] h;
    int x;
    h = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      if (i == 0 || x != 0) h[7*i +: 7] = segtab[x % 10];
      else                  h[7*i +: 7] = 7'h7f;
      x = x / 10;
    end
    return h;
  endfunction

  function automatic logic [34:0] exp_err(int nd);
    logic [34:0] h;
    h = '0;
    for (int i = 0; i < nd; i++) h[7*i +: 7] = 7'h06;
    return h;
  endfunction

  function automatic int ndig(int k);
    return (k == 0) ? 5 : 3;
  endfunction

  task automatic push_exp(int k, int v);
    exp_t e;
    e.h = exp_hex(v, ndig(k));
    e.v = 16'(v);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
    end
  endtask

  // Terms shown from a fresh start: 0, then each term until the next one no longer fits.
  task automatic push_fib_run(int k, int maxv);
    int a, b, t;
    a = 0;
    b = 1;
    push_exp(k, 0);
    while (b <= maxv) begin
      t = a + b;
      a = b;
      b = t;
      push_exp(k, a);
    end
  endtask

  // Monitor: a busy fall marks the UPDATE cycle; the new display is sampled one cycle later.
  logic prev_busy[3] = '{1'b0, 1'b0, 1'b0};
  logic due[3]       = '{1'b0, 1'b0, 1'b0};
  exp_t mon_e;
  int   ovf_len    = 0;
  int   ovf_pulses = 0;
  int   ovf_maxlen = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (due[k]) begin
        if (qsize(k) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update[%0d]: value %0d shown, none expected", k, vl[k]);
        end else begin
          mon_e = pop_exp(k);
          check($sformatf("hex[%0d]", k), 64'(hx[k]), 64'(mon_e.h));
          check($sformatf("value[%0d]", k), 64'(vl[k]), 64'(mon_e.v));
        end
      end
      due[k]       = prev_busy[k] && !bz[k] && rst[k];
      prev_busy[k] = bz[k];
    end
    if (rst[2]) begin
      if (of[2]) ovf_len++;
      else if (ovf_len > 0) begin
        ovf_pulses++;
        if (ovf_len > ovf_maxlen) ovf_maxlen = ovf_len;
        ovf_len = 0;
      end
    end
  end

  task automatic wait_empty(int k, int budget);
    int n;
    n = 0;
    while (qsize(k) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qsize(k) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout[%0d]: %0d updates outstanding, 0 required", k, qsize(k));
    end
  endtask

  task automatic wait_ovf(int k, int budget);
    int n;
    n = 0;
    while (!of[k] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ovf_set[%0d]", k), 64'(of[k]), 64'd1);
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_step(int k);
    step[k] = 1'b1;
    cycles(1);
    step[k] = 1'b0;
  endtask

  task automatic pulse_restart(int k);
    rsr[k] = 1'b1;
    cycles(1);
    rsr[k] = 1'b0;
  endtask

  task automatic check_reset_state(int k, string tag);
    check($sformatf("%s_hex[%0d]", tag, k), 64'(hx[k]), 64'(exp_hex(0, ndig(k))));
    check($sformatf("%s_value[%0d]", tag, k), 64'(vl[k]), 64'd0);
    check($sformatf("%s_busy[%0d]", tag, k), 64'(bz[k]), 64'd0);
    check($sformatf("%s_ovf[%0d]", tag, k), 64'(of[k]), 64'd0);
  endtask

  task automatic thread_a();
    push_fib_run(0, 65535);
    cycles($urandom_range(0, 5));
    rst[0] = 1'b1;
    run[0] = 1'b1;
    wait_empty(0, 3000);
    wait_ovf(0, 300);
    cycles(20);
    check("err_hex[0]", 64'(hx[0]), 64'(exp_err(5)));
    check("err_value[0]", 64'(vl[0]), 64'd46368);
  endtask

  task automatic thread_b();
    int ma, mb, t, gap, cnt, n;
    push_fib_run(1, 255);
    rst[1] = 1'b1;
    run[1] = 1'b1;
    wait_empty(1, 2000);
    wait_ovf(1, 200);
    cycles(2);
    check("err_hex[1]", 64'(hx[1]), 64'(exp_err(3)));
    cycles(40);
    check("err_hold_hex[1]", 64'(hx[1]), 64'(exp_err(3)));
    check("err_hold_value[1]", 64'(vl[1]), 64'd233);
    check("err_hold_ovf[1]", 64'(of[1]), 64'd1);
    run[1] = 1'b0;
    push_exp(1, 0);
    pulse_restart(1);
    check("restart_ovf[1]", 64'(of[1]), 64'd0);
    wait_empty(1, 100);

    // Single steps with random spacing; busy spans LOAD plus WIDTH conversion cycles.
    ma = 0;
    mb = 1;
    for (int i = 0; i < 3; i++) begin
      gap = $urandom_range(30, 60);
      t = ma + mb; ma = mb; mb = t;
      push_exp(1, ma);
      pulse_step(1);
      cnt = 0;
      for (int j = 0; j < 14; j++) begin
        @(negedge clk);
        if (bz[1]) cnt++;
      end
      check($sformatf("busy_len_step%0d", i), 64'(cnt), 64'd9);
      cycles(gap);
    end
    check("steps_drained", 64'(qsize(1)), 64'd0);
    cycles(100);
    check("idle_value", 64'(vl[1]), 64'd2);

    // Two steps two cycles apart plus a third while the pending slot is full.
    push_exp(1, 0);
    pulse_restart(1);
    wait_empty(1, 100);
    push_exp(1, 1);
    push_exp(1, 1);
    pulse_step(1);
    cycles(1);
    pulse_step(1);
    cycles(2);
    pulse_step(1);
    wait_empty(1, 200);
    cycles(40);
    check("pending_value", 64'(vl[1]), 64'd1);

    // Restart and step together: restart wins.
    push_exp(1, 0);
    rsr[1]  = 1'b1;
    step[1] = 1'b1;
    cycles(1);
    rsr[1]  = 1'b0;
    step[1] = 1'b0;
    wait_empty(1, 100);
    cycles(5);
    check("restart_wins_value", 64'(vl[1]), 64'd0);

    // A few steps, then reset lands in the middle of the next conversion.
    ma = 0;
    mb = 1;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      t = ma + mb; ma = mb; mb = t;
      push_exp(1, ma);
      pulse_step(1);
      wait_empty(1, 100);
      cycles($urandom_range(2, 10));
    end
    pulse_step(1);
    cycles($urandom_range(2, 6));
    check("busy_mid_convert", 64'(bz[1]), 64'd1);
    rst[1] = 1'b0;
    #1;
    check_reset_state(1, "midreset");
    cycles(2);
    push_exp(1, 0);
    rst[1] = 1'b1;
    wait_empty(1, 100);
    cycles(20);
    check("post_reset_value", 64'(vl[1]), 64'd0);
  endtask

  task automatic thread_c();
    push_fib_run(2, 255);
    push_exp(2, 0);
    push_exp(2, 1);
    push_exp(2, 1);
    push_exp(2, 2);
    cycles($urandom_range(0, 5));
    rst[2] = 1'b1;
    run[2] = 1'b1;
    wait_empty(2, 3000);
    rst[2] = 1'b0;
    run[2] = 1'b0;
    check("wrap_ovf_pulses", 64'(ovf_pulses), 64'd1);
    check("wrap_ovf_len", 64'(ovf_maxlen), 64'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k]  = 1'b1;
      run[k]  = 1'b0;
      step[k] = 1'b0;
      rsr[k]  = 1'b0;
    end
    #2;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    cycles(3);
    for (int k = 0; k < 3; k++) check_reset_state(k, "reset");
    fork
      thread_a();
      thread_b();
      thread_c();
    join
    check("final_queue[0]", 64'(qsize(0)), 64'd0);
    check("final_queue[1]", 64'(qsize(1)), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fib_seq_display.md
Name: fib_seq_display

Overview:
Parametrised Fibonacci sequence generator with a sequential binary-to-BCD converter and a multi-digit active-low 7-segment driver. It advances one term per prescaled tick and supports run/pause, single-step and restart. It detects arithmetic overflow and either shows an error pattern or wraps back to the start of the sequence. It is the board-level display block and drives HEX digits directly from the system clock domain.

Parameters:
WIDTH, 16, bit width of sequence terms (>=4)
DIGITS, 5, number of 7-seg digits; must satisfy 10^DIGITS > 2^WIDTH-1
TICK_DIV, 25000000, clk cycles per auto-advance tick (>=2)
WRAP_ON_OVF, 0, 0 = freeze and show error on overflow; 1 = restart sequence at 0,1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = auto-advance on each tick
step  in  1  single-cycle pulse; advance one term when run=0 (ignored when run=1)
restart  in  1  single-cycle pulse; synchronous return to term 0
hex  out  DIGITS*7  segment bits, digit i at [7i+6:7i], active-low, bit order gfedcba
value  out  WIDTH  current displayed term (binary)
ovf  out  1  sticky overflow flag
busy  out  1  high while a BCD conversion is in progress

Behaviour:
- Reset (reset=0, asynchronous): cur=0, nxt=1, tick counter=0, ovf=0, pending=0, FSM=LOAD, hex: digit0 shows "0" (1000000), all other digits blank (1111111), value=0, busy=0.
- Tick counter: counts 0..TICK_DIV-1 and wraps; tick=1 for one cycle at TICK_DIV-1. Counter resets to 0 on restart.
- Advance request: (run & tick) | (~run & step). If ovf=1 and WRAP_ON_OVF=0, all advance requests are ignored.
- Advance: sum = cur + nxt computed at WIDTH+1 bits; cur<=nxt; nxt<=sum[WIDTH-1:0].
- Overflow: set when the term about to be loaded into cur has carry, i.e. nxt came from a sum with bit WIDTH set (tracked with a nxt_ovf bit). For WIDTH=8, the sequence shows 233, and the next advance overflows.
  - WRAP_ON_OVF=0: ovf<=1 (sticky until reset or restart); cur unchanged; display shows "E" (0000110) on all digits.
  - WRAP_ON_OVF=1: cur<=0, nxt<=1; ovf pulses high for 1 cycle.
- FSM states:
  - IDLE: wait for an advance request.
  - LOAD: latch cur into the shift register, clear BCD accumulator, busy=1.
  - CONVERT: double-dabble, exactly WIDTH iterations (add 3 to each nibble >=5, then shift left 1).
  - UPDATE: write hex/value from BCD with leading-zero blanking (digit0 never blanked), busy=0, go to IDLE.
- Transitions: an advance in IDLE updates cur and enters LOAD in the same cycle.
- Latency: advance request to hex update = WIDTH+2 cycles.
- Advance during LOAD/CONVERT/UPDATE: set pending (depth 1; further requests are dropped). On entering IDLE with pending=1, perform the advance immediately and clear pending.
- restart: highest priority over advance and step in the same cycle. Sets cur=0, nxt=1, ovf=0, pending=0 and aborts any conversion (FSM->LOAD). The displayed value holds until the new UPDATE.
- hex and value change only in UPDATE (or reset, or error display), so no partial values are ever visible.
- Asserting reset mid-conversion returns immediately to the reset state.

Decomposition:
- Package fib_pkg: 7-seg constants SEG_0..SEG_9, SEG_BLANK, SEG_E; FSM state enum {IDLE, LOAD, CONVERT, UPDATE}; function clog2.
- One sub-module: bin2bcd_seq (parameters WIDTH, DIGITS; ports start/done handshake, bin in, bcd out). This is the sequential double-dabble and is reusable by other display blocks.
- Segment decode is a package function; the sequence registers, FSM and tick counter stay in the top module.

Test Plan:
- Reset with WIDTH=16, DIGITS=5, TICK_DIV=4, run=1 -> hex shows "0" with 4 blanks, value=0; then successive UPDATEs show 1,1,2,3,5,8,13,21,34,55,89.
- WIDTH=8, DIGITS=3, WRAP_ON_OVF=0, run=1 -> values run up to 233, then ovf=1 and hex=EEE held for 10 further ticks; restart pulse -> ovf=0, display returns to 0.
- Same configuration with WRAP_ON_OVF=1 -> 233 is followed by 0,1,1,2; ovf pulses for exactly 1 cycle.
- run=0, three step pulses spaced 30 cycles apart -> values 1,1,2; no change over 100 cycles without a step; busy is high for WIDTH+1 cycles after each step.
- Two step pulses 2 cycles apart, then a third during busy -> exactly two advances; final value=1 (second term) and pending is cleared.
- restart and step in the same cycle, and reset asserted mid-CONVERT -> restart wins (value 0); reset gives the reset-state outputs with no UPDATE afterwards.
